vram_write_arbiter: RTL

VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

---
 rtl/gpu_pkg.sv | 10 +
 rtl/vram_wr_fifo.sv | 39 +++
 rtl/vram_write_arbiter.sv | 79 +++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared VRAM widths, write-owner encoding and write record
package gpu_pkg;
  localparam int VRAM_AW = 16;
  localparam int VRAM_DW = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, CPU = 2'd2} owner_t;
  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] data;
  } vram_wr_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: DEPTH-entry circular buffer of pending CPU VRAM writes
// Ports: clk, rst (async, active-high); push/din enqueue; pop dequeues head;
// head is the oldest entry; count/full/empty report occupancy.
// The caller must not push when full nor pop when empty.
module vram_wr_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  vram_wr_t               din,
  output vram_wr_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  vram_wr_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign head  = mem[rp];
  assign full  = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: merges buffered CPU writes and clear-engine writes onto one VRAM write port
// Ports: clk, rst (async, active-high);
//   cpu_we/cpu_write_address/cpu_write_data in, cpu_full out (CPU side, buffered);
//   clr_req/clr_waddr/clr_wdata in, clr_grant out (clear engine, combinational grant);
//   vram_we/vram_write_address/vram_write_data out (registered VRAM port);
//   cpu_drop_cnt out (dropped CPU writes, live only with VRAM_ARB_DROP_STATS_EN).
// Build option: define VRAM_ARB_DROP_STATS_EN to enable the saturating drop counter.
module vram_write_arbiter
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_write_address,
  input  logic [VRAM_DW-1:0] cpu_write_data,
  output logic               cpu_full,
  input  logic               clr_req,
  input  logic [VRAM_AW-1:0] clr_waddr,
  input  logic [VRAM_DW-1:0] clr_wdata,
  output logic               clr_grant,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_write_address,
  output logic [VRAM_DW-1:0] vram_write_data,
  output logic [15:0]        cpu_drop_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  vram_wr_t head;
  logic [CW-1:0] count;
  logic full, empty, push, cpu_grant;
  logic [SW-1:0] starve_cnt;
  owner_t state;
  assign cpu_full  = count == CW'(FIFO_DEPTH);
  // A write arriving while full is lost even if the head leaves this cycle.
  assign push      = cpu_we && !full;
  assign clr_grant = !rst && clr_req && (empty || starve_cnt < SW'(STARVE_LIMIT));
  assign cpu_grant = !rst && !clr_grant && !empty;
  // The registered owner doubles as the write strobe: one cycle per grant.
  assign vram_we   = state != IDLE;
  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (cpu_grant),
    .din  ({cpu_write_address, cpu_write_data}),
    .head (head),
    .count(count),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state              <= IDLE;
      vram_write_address <= '0;
      vram_write_data    <= '0;
      starve_cnt         <= '0;
    end else begin
      state <= clr_grant ? CLR : cpu_grant ? CPU : IDLE;
      if (clr_grant) begin
        vram_write_address <= clr_waddr;
        vram_write_data    <= clr_wdata;
      end else if (cpu_grant) begin
        vram_write_address <= head.addr;
        vram_write_data    <= head.data;
      end
      starve_cnt <= (empty || cpu_grant) ? '0 :
                    (clr_grant && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
    end
`ifdef VRAM_ARB_DROP_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) cpu_drop_cnt <= '0;
    else if (cpu_we && cpu_full && cpu_drop_cnt != 16'hFFFF) cpu_drop_cnt <= cpu_drop_cnt + 1'b1;
`else
  assign cpu_drop_cnt = '0;
`endif
endmodule
